// File: rtl/dreq_priority_arbiter.sv
// DMA request arbiter: picks one DREQ channel per bus tenure and sequences the
// HREQ/HLDA hold handshake with the processor, driving a one-hot DACK.
module dreq_priority_arbiter #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned HOLD_MAX = 16,
  localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] dreq,
  input  logic [NCH-1:0] chan_mask,
  input  logic           rotate_en,
  input  logic           demand_mode,
  input  logic           hlda,
  input  logic           xfer_done,
  input  logic           tc,
  output logic           hreq,
  output logic [NCH-1:0] dack,
  output logic [CHW-1:0] active_ch,
  output logic           grant_valid,
  output logic           busy
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t         state;
  logic [CHW-1:0] prio_ptr;
  logic [CW-1:0]  hold_cnt;

  logic [NCH-1:0] eligible_c;
  logic [CHW-1:0] win_c;
  logic           win_found_c;
  logic           release_c;
  int unsigned    idx_c;

  assign eligible_c = dreq & ~chan_mask;

  // First eligible channel scanning upward from prio_ptr, wrapping at NCH.
  always_comb begin
    win_c       = '0;
    win_found_c = 1'b0;
    idx_c       = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx_c = 32'(prio_ptr) + i;
      if (idx_c >= NCH) idx_c = idx_c - NCH;
      if (!win_found_c && eligible_c[CHW'(idx_c)]) begin
        win_found_c = 1'b1;
        win_c       = CHW'(idx_c);
      end
    end
  end

  // End of grant: processor reclaim, terminal count, or per-mode completion.
  always_comb begin
    release_c = 1'b0;
    if (!hlda || tc) begin
      release_c = 1'b1;
    end else if (!demand_mode) begin
      release_c = xfer_done;
    end else begin
      release_c = !dreq[active_ch] ||
                  (xfer_done && (hold_cnt == CW'(HOLD_MAX - 1)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hreq        <= 1'b0;
      dack        <= '0;
      active_ch   <= '0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
      hold_cnt    <= '0;
      prio_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible_c) begin
            state <= REQ;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (hlda) begin
            if (win_found_c) begin
              state       <= GRANT;
              hreq        <= 1'b1;
              dack        <= NCH'(1) << win_c;
              active_ch   <= win_c;
              grant_valid <= 1'b1;
              hold_cnt    <= '0;
            end else begin
              state <= RELEASE;
              hreq  <= 1'b0;
            end
          end else begin
            hreq <= 1'b1;
          end
        end
        GRANT: begin
          if (xfer_done && (hold_cnt != CW'(HOLD_MAX))) hold_cnt <= hold_cnt + CW'(1);
          if (release_c) begin
            state       <= RELEASE;
            hreq        <= 1'b0;
            dack        <= '0;
            grant_valid <= 1'b0;
            if (rotate_en) begin
              prio_ptr <= (32'(active_ch) == NCH - 1) ? '0 : active_ch + CHW'(1);
            end
          end
        end
        RELEASE: begin
          if (!hlda) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dreq_priority_arbiter.sv
// Directed bench for dreq_priority_arbiter: fixed/rotating priority, demand
// fairness, withdrawal, abort, async reset and masking.
module tb_dreq_priority_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] dreq;
  logic [3:0] chan_mask;
  logic       rotate_en;
  logic       demand_mode;
  logic       hlda;
  logic       xfer_done;
  logic       tc;
  logic       hreq;
  logic [3:0] dack;
  logic [1:0] active_ch;
  logic       grant_valid;
  logic       busy;

  int n_chk;
  int n_bad;

  dreq_priority_arbiter #(.NCH(4), .HOLD_MAX(16)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .chan_mask(chan_mask),
    .rotate_en(rotate_en), .demand_mode(demand_mode), .hlda(hlda),
    .xfer_done(xfer_done), .tc(tc), .hreq(hreq), .dack(dack),
    .active_ch(active_ch), .grant_valid(grant_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for hreq; an expired bound shows up as a failed comparison.
  task automatic wait_hreq(input string tag);
    int n = 0;
    while (!hreq && n < 20) begin
      step(1);
      n++;
    end
    chk({tag, "_hreq_up"}, 32'(hreq), 32'd1);
  endtask

  // One single-mode tenure with one transfer, expecting a given winner.
  task automatic tenure(input string tag, input logic [3:0] exp_dack, input logic [1:0] exp_ch);
    wait_hreq(tag);
    hlda = 1'b1;
    step(1);
    chk({tag, "_dack"}, 32'(dack), 32'(exp_dack));
    chk({tag, "_ch"}, 32'(active_ch), 32'(exp_ch));
    xfer_done = 1'b1;
    step(1);
    xfer_done = 1'b0;
    chk({tag, "_dack_off"}, 32'(dack), 32'd0);
    hlda = 1'b0;
    step(1);
  endtask

  initial begin
    int rel_at;
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    dreq = '0; chan_mask = '0; rotate_en = 1'b0; demand_mode = 1'b0;
    hlda = 1'b0; xfer_done = 1'b0; tc = 1'b0;
    step(2);
    chk("rst_hreq", 32'(hreq), 32'd0);
    chk("rst_dack", 32'(dack), 32'd0);
    chk("rst_ch", 32'(active_ch), 32'd0);
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step(1);

    // Fixed priority: ch1 beats ch3, exact latencies.
    dreq = 4'b1010;
    step(1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_hreq_lag", 32'(hreq), 32'd0);
    step(1);
    chk("t1_hreq", 32'(hreq), 32'd1);
    hlda = 1'b1;
    step(1);
    chk("t1_dack", 32'(dack), 32'b0010);
    chk("t1_ch", 32'(active_ch), 32'd1);
    chk("t1_gv", 32'(grant_valid), 32'd1);
    xfer_done = 1'b1;
    step(1);
    xfer_done = 1'b0;
    chk("t1_hreq_off", 32'(hreq), 32'd0);
    chk("t1_dack_off", 32'(dack), 32'd0);
    chk("t1_rel_busy", 32'(busy), 32'd1);
    hlda = 1'b0;
    dreq = '0;
    step(1);
    chk("t1_idle", 32'(busy), 32'd0);

    // Rotation over all four channels and back to ch0.
    rotate_en = 1'b1;
    dreq = 4'b1111;
    tenure("rot0", 4'b0001, 2'd0);
    tenure("rot1", 4'b0010, 2'd1);
    tenure("rot2", 4'b0100, 2'd2);
    tenure("rot3", 4'b1000, 2'd3);
    tenure("rot4", 4'b0001, 2'd0);
    dreq = '0;
    rotate_en = 1'b0;
    step(2);

    // Demand fairness: forced release on the 16th transfer.
    demand_mode = 1'b1;
    dreq = 4'b0100;
    wait_hreq("dem");
    hlda = 1'b1;
    step(1);
    chk("dem_dack", 32'(dack), 32'b0100);
    rel_at = 0;
    for (int k = 1; k <= 20; k++) begin
      xfer_done = 1'b1;
      step(1);
      xfer_done = 1'b0;
      if (dack == 4'b0000) begin
        rel_at = k;
        break;
      end
      step(1);
    end
    chk("dem_rel_at", 32'(rel_at), 32'd16);
    chk("dem_hreq_off", 32'(hreq), 32'd0);
    hlda = 1'b0;
    step(1);
    chk("dem_idle", 32'(busy), 32'd0);
    wait_hreq("dem2");
    hlda = 1'b1;
    step(1);
    chk("dem2_dack", 32'(dack), 32'b0100);
    dreq = '0;
    step(1);
    chk("dem2_drop", 32'(dack), 32'd0);
    hlda = 1'b0;
    demand_mode = 1'b0;
    step(2);

    // Withdrawal before hlda: no DACK at all.
    dreq = 4'b0001;
    step(1);
    dreq = '0;
    step(1);
    chk("wd_hreq", 32'(hreq), 32'd1);
    hlda = 1'b1;
    step(1);
    chk("wd_hreq_off", 32'(hreq), 32'd0);
    chk("wd_dack", 32'(dack), 32'd0);
    chk("wd_gv", 32'(grant_valid), 32'd0);
    hlda = 1'b0;
    step(1);
    chk("wd_idle", 32'(busy), 32'd0);

    // Processor reclaim mid-grant.
    dreq = 4'b1000;
    wait_hreq("ab");
    hlda = 1'b1;
    step(1);
    chk("ab_dack", 32'(dack), 32'b1000);
    hlda = 1'b0;
    step(1);
    chk("ab_dack_off", 32'(dack), 32'd0);
    chk("ab_rel_busy", 32'(busy), 32'd1);
    dreq = '0;
    step(1);
    chk("ab_idle", 32'(busy), 32'd0);

    // Async reset mid-grant.
    dreq = 4'b0001;
    wait_hreq("ar");
    hlda = 1'b1;
    step(1);
    chk("ar_dack", 32'(dack), 32'b0001);
    #2 reset = 1'b0;
    #1;
    chk("ar_hreq", 32'(hreq), 32'd0);
    chk("ar_dack_off", 32'(dack), 32'd0);
    chk("ar_gv", 32'(grant_valid), 32'd0);
    hlda = 1'b0;
    dreq = '0;
    step(1);
    reset = 1'b1;
    step(1);

    // Masked channel never requests the bus.
    chan_mask = 4'b0001;
    dreq = 4'b0001;
    step(5);
    chk("mask_hreq", 32'(hreq), 32'd0);
    chk("mask_busy", 32'(busy), 32'd0);
    dreq = '0;
    chan_mask = '0;
    step(1);

    // Demand grant ended by tc; mask change mid-grant is ignored.
    demand_mode = 1'b1;
    dreq = 4'b0010;
    wait_hreq("tc");
    hlda = 1'b1;
    step(1);
    chk("tc_dack", 32'(dack), 32'b0010);
    chan_mask = 4'b0010;
    xfer_done = 1'b1;
    step(1);
    xfer_done = 1'b0;
    chk("tc_hold", 32'(dack), 32'b0010);
    tc = 1'b1;
    xfer_done = 1'b1;
    step(1);
    tc = 1'b0;
    xfer_done = 1'b0;
    chk("tc_dack_off", 32'(dack), 32'd0);
    chk("tc_hreq_off", 32'(hreq), 32'd0);
    hlda = 1'b0;
    dreq = '0;
    chan_mask = '0;
    step(2);
    chk("end_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
